// File: rtl/spi_mem_pkg.sv
// Shared types and command opcodes for the SPI memory access controller.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

endpackage

// File: rtl/spi_mem_ctrl_clk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV enabled cycles, starting low, and
// flags the cycle whose closing clk edge produces a rising or falling SCLK edge.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          edge_due;

  assign edge_due = en && (div_cnt == DW'(CLK_DIV - 1));
  assign rise_stb = edge_due && !sclk;
  assign fall_stb = edge_due && sclk;

  // Dropping en parks sclk low and rewinds the divider, so every SHIFT entry
  // starts with a full first half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (edge_due) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: serves READ/WRITE requests of 1..MAX_BYTES
// bytes over a valid/ready channel with SCLK divided down from clk.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int MAX_BYTES = 4,
  parameter int CLK_DIV   = 2,
  parameter int CS_SETUP  = 4,
  parameter int CS_HOLD   = 4,
  parameter int LEN_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [LEN_W-1:0]       req_len,
  input  logic [8*MAX_BYTES-1:0] req_wdata,
  input  logic                   abort,
  output logic                   rsp_valid,
  output logic [8*MAX_BYTES-1:0] rsp_rdata,
  output logic                   busy,
  output logic                   sclk,
  output logic                   mosi,
  output logic                   cs_n,
  input  logic                   miso
);

  localparam int RD_W    = 8 * MAX_BYTES;
  localparam int HDR_W   = 8 + ADDR_W;
  localparam int TX_W    = HDR_W + RD_W;
  localparam int CNT_W   = $clog2(TX_W + 1);
  localparam int RIDX_W  = $clog2(RD_W);
  localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  state_t            state;
  logic [TMR_W-1:0]  tmr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  n_last;
  logic [LEN_W-1:0]  len_c;
  logic [LEN_W-1:0]  len_q;
  logic              write_q;
  logic              aborted;
  logic [TX_W-1:0]   tx_sr;
  logic [TX_W-1:0]   tx_load;
  logic [RIDX_W-1:0] rx_idx;
  logic              in_data;
  logic              clk_en;
  logic              rise_stb;
  logic              fall_stb;

  assign len_c   = (req_len > LEN_W'(MAX_BYTES - 1)) ? LEN_W'(MAX_BYTES - 1) : req_len;
  assign n_last  = CNT_W'(HDR_W + 8 * (int'(len_q) + 1) - 1);
  assign in_data = bit_cnt >= CNT_W'(HDR_W);
  // Data bit d lands in byte d/8 at position 7-d%8, i.e. index d with the low 3 bits inverted.
  assign rx_idx  = RIDX_W'(bit_cnt - CNT_W'(HDR_W)) ^ RIDX_W'(7);
  assign clk_en  = (state == ST_SHIFT) && !abort;

  always_comb begin
    tx_load = '0;
    tx_load[TX_W-1 -: 8] = req_write ? CMD_WRITE : CMD_READ;
    tx_load[TX_W-9 -: ADDR_W] = req_addr;
    if (req_write) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        tx_load[RD_W-1-8*i -: 8] = req_wdata[8*i +: 8];
      end
    end
  end

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (clk_en),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid) begin
      tx_sr <= tx_load;
    end else if (state == ST_SHIFT && fall_stb) begin
      tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      tmr       <= '0;
      bit_cnt   <= '0;
      len_q     <= '0;
      write_q   <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            len_q     <= len_c;
            aborted   <= 1'b0;
            rsp_rdata <= '0;
            cs_n      <= 1'b0;
            mosi      <= tx_load[TX_W-1];
            req_ready <= 1'b0;
            busy      <= 1'b1;
            tmr       <= '0;
            bit_cnt   <= '0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (abort) begin
            aborted <= 1'b1;
            mosi    <= 1'b0;
            tmr     <= '0;
            state   <= ST_HOLD;
          end else if (tmr == TMR_W'(CS_SETUP - 1)) begin
            tmr   <= '0;
            state <= ST_SHIFT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            aborted <= 1'b1;
            mosi    <= 1'b0;
            tmr     <= '0;
            state   <= ST_HOLD;
          end else begin
            if (rise_stb && in_data && !write_q) begin
              rsp_rdata[rx_idx] <= miso;
            end
            if (fall_stb) begin
              mosi    <= tx_sr[TX_W-2];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == n_last) begin
                mosi  <= 1'b0;
                tmr   <= '0;
                state <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tmr == TMR_W'(CS_HOLD - 1)) begin
            cs_n <= 1'b1;
            if (aborted) begin
              req_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              rsp_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: behavioural SPI memory, directed vector table,
// multi-cycle corner sequences and randomized transactions.
module tb_spi_mem_ctrl;

  localparam int ADDR_W    = 24;
  localparam int MAX_BYTES = 4;
  localparam int CLK_DIV   = 2;
  localparam int CS_SETUP  = 4;
  localparam int CS_HOLD   = 4;
  localparam int MEM_SZ    = 131072;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [23:0] req_addr = '0;
  logic [1:0]  req_len = '0;
  logic [31:0] req_wdata = '0;
  logic        abort = 1'b0;
  logic        miso = 1'b0;
  logic        req_ready, rsp_valid, busy, sclk, mosi, cs_n;
  logic [31:0] rsp_rdata;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  spi_mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .abort     (abort),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .miso      (miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SPI memory: records every MOSI bit, answers READ data MSB first.
  logic [7:0] mem [MEM_SZ];
  bit         cap_q[$];
  int         rise_cnt = 0;
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;
  logic [7:0] s_cmd = '0;
  int         s_addr = 0;

  always @(negedge clk) begin
    if (!cs_n) begin
      if (prev_cs) begin
        cap_q.delete();
        rise_cnt = 0;
      end
      if (sclk && !prev_sclk) begin
        cap_q.push_back(mosi);
        rise_cnt++;
        if (rise_cnt == 8 + ADDR_W) begin
          s_cmd = '0;
          s_addr = 0;
          for (int i = 0; i < 8; i++) s_cmd = {s_cmd[6:0], cap_q[i]};
          for (int i = 8; i < 8 + ADDR_W; i++) s_addr = (s_addr << 1) | int'(cap_q[i]);
        end
      end else if (!sclk && prev_sclk && rise_cnt >= 8 + ADDR_W && s_cmd == 8'h03) begin
        int d;
        d = rise_cnt - (8 + ADDR_W);
        miso = mem[(s_addr + d / 8) % MEM_SZ][7 - d % 8];
      end
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input bit wr, input logic [23:0] a, input logic [1:0] l);
    logic [31:0] v = '0;
    if (!wr) for (int k = 0; k <= int'(l); k++) v[8*k +: 8] = mem[(int'(a) + k) % MEM_SZ];
    return v;
  endfunction

  function automatic logic [63:0] model_mosi(input bit wr, input logic [23:0] a, input logic [1:0] l,
                                             input logic [31:0] wd);
    logic [63:0] v;
    v = {32'h0, (wr ? 8'h02 : 8'h03), a};
    for (int k = 0; k <= int'(l); k++) v = (v << 8) | (wr ? 64'(wd[8*k +: 8]) : 64'h0);
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    if (!req_ready) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_rsp(input string nm, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 2000) begin
      tick();
      n++;
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk({nm, "_rsp_timeout"}, 0, 1);
  endtask

  task automatic run_txn(input string nm, input bit wr, input logic [23:0] a, input logic [1:0] l,
                         input logic [31:0] wd, input bit ab, input logic [31:0] exp_rd,
                         input logic [63:0] exp_mosi);
    int t0, nb, lat;
    bit ok;
    logic [63:0] cv;
    logic [31:0] rd;
    nb = 8 + ADDR_W + 8 * (int'(l) + 1);
    wait_ready(nm);
    req_write = wr; req_addr = a; req_len = l; req_wdata = wd; abort = ab;
    req_valid = 1'b1;
    t0 = cyc;
    tick();
    req_valid = 1'b0; abort = 1'b0;
    chk({nm, "_ready_drop"}, req_ready, 0);
    chk({nm, "_cs_fall"}, cs_n, 0);
    wait_rsp(nm, ok);
    if (ok) begin
      lat = cyc - t0 + 1;
      rd = rsp_rdata;
      chk({nm, "_latency"}, lat, 1 + CS_SETUP + 2 * CLK_DIV * nb + CS_HOLD + 1);
      chk({nm, "_rdata"}, rd, exp_rd);
      chk({nm, "_rise_cnt"}, rise_cnt, nb);
      cv = '0;
      foreach (cap_q[i]) cv = (cv << 1) | 64'(cap_q[i]);
      chk({nm, "_mosi_len"}, cap_q.size(), nb);
      chk({nm, "_mosi"}, cv, exp_mosi);
      tick();
      chk({nm, "_single_pulse"}, rsp_valid, 0);
      chk({nm, "_idle"}, {busy, req_ready, cs_n}, 3'b011);
      tick();
      chk({nm, "_rdata_hold"}, rsp_rdata, rd);
    end
  endtask

  typedef struct {
    string       nm;
    bit          wr;
    logic [23:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [63:0] exp_mosi;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int  n;
    bit  ok, saw_rsp;
    bit  wr, ab;
    logic [23:0] a;
    logic [1:0]  l;
    logic [31:0] wd;

    for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
    mem[24'h001234] = 8'hEF; mem[24'h001235] = 8'hBE;
    mem[24'h001236] = 8'hAD; mem[24'h001237] = 8'hDE;
    mem[24'h00FFFF] = 8'h7C;
    for (int i = 0; i < 4; i++) mem[24'h002000 + i] = 8'hFF;

    vecs[0] = '{"rd4",  1'b0, 24'h001234, 2'd3, 32'h0,        32'hDEADBEEF, 64'h03001234_00000000};
    vecs[1] = '{"wr2",  1'b1, 24'h000100, 2'd1, 32'h0000A55A, 32'h0,        64'h0000_020001005AA5};
    vecs[2] = '{"rd1",  1'b0, 24'h00FFFF, 2'd0, 32'h0,        32'h0000007C, 64'h000000_0300FFFF00};

    tick();
    chk("reset_outputs", {cs_n, sclk, mosi, req_ready, rsp_valid, busy}, 6'b100100);
    chk("reset_rdata", rsp_rdata, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      run_txn(vecs[i].nm, vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wdata, 1'b0,
              vecs[i].exp_rd, vecs[i].exp_mosi);

    // Abort at the 20th SCLK rising edge of a READ.
    wait_ready("abort");
    req_write = 1'b0; req_addr = 24'h003000; req_len = 2'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (rise_cnt < 20 && n < 2000) begin tick(); n++; end
    chk("abort_reach20", rise_cnt, 20);
    abort = 1'b1;
    saw_rsp = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_sclk_low", sclk, 0);
    n = 1;
    while (!cs_n && n < 50) begin tick(); n++; if (rsp_valid) saw_rsp = 1'b1; end
    chk("abort_cs_hold", n, 1 + CS_HOLD);
    chk("abort_ready", {req_ready, busy}, 2'b10);
    for (int i = 0; i < 6; i++) begin tick(); if (rsp_valid) saw_rsp = 1'b1; end
    chk("abort_no_rsp", saw_rsp, 0);
    run_txn("post_abort", 1'b0, 24'h001234, 2'd3, 32'h0, 1'b0, 32'hDEADBEEF,
            model_mosi(1'b0, 24'h001234, 2'd3, 32'h0));

    // Asynchronous reset in the data phase of a READ.
    wait_ready("rst");
    req_write = 1'b0; req_addr = 24'h002000; req_len = 2'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (rise_cnt < 45 && n < 2000) begin tick(); n++; end
    chk("rst_pre_rdata_nonzero", rsp_rdata != 0, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_pins", {cs_n, sclk, busy, req_ready}, 4'b1001);
    chk("rst_async_rdata", rsp_rdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back with req_valid held high.
    wait_ready("b2b");
    req_write = 1'b0; req_addr = 24'h001234; req_len = 2'd3; req_valid = 1'b1;
    tick();
    wait_rsp("b2b1", ok);
    if (ok) begin
      chk("b2b1_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("b2b_ready_in_done", req_ready, 0);
      req_addr = 24'h00FFFF; req_len = 2'd0;
      tick();
      chk("b2b_gap", {cs_n, req_ready}, 2'b11);
      tick();
      req_valid = 1'b0;
      chk("b2b_second_accept", {cs_n, req_ready}, 2'b00);
      wait_rsp("b2b2", ok);
      if (ok) chk("b2b2_rdata", rsp_rdata, 32'h0000007C);
    end
    req_valid = 1'b0;

    // Randomized traffic against the reference model; abort sometimes coincides with acceptance.
    for (int i = 0; i < 12; i++) begin
      wr = 1'($urandom);
      a  = 24'($urandom_range(0, 24'h01FFF0));
      l  = 2'($urandom);
      wd = $urandom;
      ab = ($urandom_range(0, 3) == 0);
      run_txn($sformatf("rand%0d", i), wr, a, l, wd, ab, model_rd(wr, a, l), model_mosi(wr, a, l, wd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
